// File: rtl/ir_pkg.sv
// Shared defaults and the instruction type for the instruction-register queue.
// Build option consumed by ir_queue: IR_QUEUE_BYPASS_EN.
package ir_pkg;

    localparam int INSTR_W_DEF = 10;
    localparam int LOW_W_DEF   = 4;
    localparam int DEPTH_DEF   = 4;

    typedef logic [INSTR_W_DEF-1:0] instr_t;

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x INSTR_W register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owning queue.
module ir_queue_mem
    import ir_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction-register FIFO between memory and decoder, with flush on branch and sticky overflow.
// Optional IR_QUEUE_BYPASS_EN: an empty queue forwards instr_in to ir_out in the same cycle.
module ir_queue
    import ir_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int LOW_W   = LOW_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    output logic [INSTR_W-1:0]         ir_out,
    output logic [LOW_W-1:0]           ir_out_low,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt_q;
    logic               overflow_q;

    logic               stored;
    logic               full_int;
    logic               do_pop;
    logic               do_push;
    logic               drop;
    logic               mem_we;
    logic [PTR_W-1:0]   mem_waddr;
    logic [INSTR_W-1:0] rdata;

`ifdef IR_QUEUE_BYPASS_EN
    logic               bypass;
    assign bypass = (cnt_q == '0) && push && !flush;
`endif

    always_comb begin
        stored   = (cnt_q != '0);
        full_int = (cnt_q == CNT_W'(DEPTH));
        do_pop   = pop && stored;
        drop     = push && full_int && !pop;
`ifdef IR_QUEUE_BYPASS_EN
        // A bypassed instruction that is popped in the same cycle is never stored.
        do_push  = push && !drop && !(bypass && pop);
`else
        do_push  = push && !drop;
`endif
        mem_we    = !rst && (flush ? push : do_push);
        mem_waddr = flush ? '0 : wr_ptr;
    end

    ir_queue_mem #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (instr_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            // A push alongside flush becomes the sole entry (branch target) at slot 0.
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_W'(1) : '0;
            cnt_q  <= push ? CNT_W'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        count    = cnt_q;
        full     = full_int;
        overflow = overflow_q;
`ifdef IR_QUEUE_BYPASS_EN
        valid  = stored || bypass;
        ir_out = stored ? rdata : (bypass ? instr_in : '0);
`else
        valid  = stored;
        ir_out = stored ? rdata : '0;
`endif
        ir_out_low = ir_out[LOW_W-1:0];
    end

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 10, meaning instruction width in bits.
REQ-002 The block SHALL have parameter LOW_W, default 4, meaning width of the low operand field, instr[LOW_W-1:0], with LOW_W < INSTR_W.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries, a power of two and at least 2.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port instr_in, input, INSTR_W bits: instruction from memory.
REQ-008 The block SHALL have port push, input, 1 bit: write instr_in into the queue (IRload).
REQ-009 The block SHALL have port pop, input, 1 bit: decoder consumes the head entry.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all entries (branch taken).
REQ-011 The block SHALL have port ir_out, output, INSTR_W bits: head instruction.
REQ-012 The block SHALL have port ir_out_low, output, LOW_W bits: head instruction low field.
REQ-013 The block SHALL have port valid, output, 1 bit: head entry present.
REQ-014 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH+1) bits: occupied entries.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped push.

Function
REQ-017 The block SHALL operate as a FIFO; entries are written at the write pointer and read at the read pointer, and both pointers wrap modulo DEPTH.
REQ-018 An accepted push SHALL appear on ir_out no earlier than the next cycle, with valid high from that cycle.
REQ-019 ir_out_low SHALL always equal ir_out[LOW_W-1:0].
REQ-020 When valid=0, ir_out and ir_out_low SHALL be driven to zero.
REQ-021 A pop while valid=0 SHALL be ignored with no pointer or count change.
REQ-022 A push while full=1 and pop=0 SHALL be dropped and SHALL set overflow to 1.
REQ-023 A push while full=1 and pop=1 SHALL be accepted; count stays DEPTH and overflow is unchanged.
REQ-024 Push and pop in the same cycle with 0<count<DEPTH SHALL leave count unchanged.
REQ-025 flush=1 SHALL set count to 0 and both pointers to 0 at the next edge, overriding pop.
REQ-026 flush=1 with push=1 in the same cycle SHALL leave exactly one entry, the pushed instr_in (branch target), with count=1.
REQ-027 overflow SHALL clear only on rst; flush SHALL NOT clear it.
REQ-028 full, valid and count SHALL be derived from registered state only.

Reset
REQ-029 On rst=1 at a rising edge, count, both pointers and overflow SHALL become 0, so that valid=0, full=0 and ir_out=ir_out_low=0.
REQ-030 rst SHALL override push, pop and flush; storage contents need not be cleared.
REQ-031 Reset asserted mid-stream SHALL discard all queued entries.

Configuration
REQ-032 Macro IR_QUEUE_BYPASS_EN SHALL be the only compile-time option.
REQ-033 With IR_QUEUE_BYPASS_EN defined and count=0, push=1, flush=0, the block SHALL drive ir_out=instr_in and valid=1 combinationally in the same cycle.
REQ-034 In that bypass case, pop=1 in the same cycle SHALL consume the instruction without storing it, and count stays 0.
REQ-035 Without IR_QUEUE_BYPASS_EN, the latency of REQ-018 SHALL apply unconditionally and no combinational path from instr_in to ir_out SHALL exist.

Structure
REQ-036 Package ir_pkg SHALL hold the default constants INSTR_W_DEF=10, LOW_W_DEF=4 and DEPTH_DEF=4, plus typedef instr_t of INSTR_W_DEF bits.
REQ-037 Storage SHALL be a sub-module ir_queue_mem, a DEPTH x INSTR_W register array with one write port and one asynchronous read port; the pointer and count control SHALL stay in ir_queue.

Verification
REQ-038 Scenario "in order": rst, then push 0x3A5, 0x001, 0x2FF on consecutive cycles, then pop x3 -> ir_out shows 0x3A5, 0x001, 0x2FF in order, ir_out_low shows 0x5, 0x1, 0xF, and count ends at 0 with valid=0.
REQ-039 Scenario "overflow": push 5 values with DEPTH=4 and no pop -> full=1 after the 4th push, the 5th value is dropped, overflow=1, and the head is still the first value.
REQ-040 Scenario "full plus push/pop": at full, push=pop=1 with 0x155 -> count stays 4, overflow stays 0, and 0x155 emerges after 3 more pops.
REQ-041 Scenario "flush with push": queue holds 3 entries, then flush=1 and push=1 with 0x0C3 -> next cycle count=1 and ir_out=0x0C3.
REQ-042 Scenario "reset mid-operation": with 2 entries and overflow=1, assert rst for 1 cycle -> count=0, valid=0, overflow=0 and ir_out=0.
REQ-043 Scenario "bypass": with IR_QUEUE_BYPASS_EN defined and the queue empty, push=1 and pop=1 with 0x2AA -> ir_out=0x2AA and valid=1 in the same cycle, then count=0 next cycle; without the macro -> valid=0 in the same cycle, and 0x2AA is head next cycle with count=1.
